// File: rtl/sreg_pkg.sv
// Shared definitions for the serial address-register load controller:
// FSM state encoding and default word/counter widths.
package sreg_pkg;

   localparam int DWIDTH_DEF = 21;
   localparam int CWIDTH_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

endpackage

// File: rtl/sreg_bitcnt.sv
// Loadable bit counter for the serial frame. tc flags the increment that
// takes the count to DWIDTH, i.e. the final bit of a complete word.
module sreg_bitcnt
   import sreg_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int CWIDTH = CWIDTH_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic inc,
   output logic tc
);

   localparam logic [CWIDTH-1:0] LAST = CWIDTH'(DWIDTH - 1);

   logic [CWIDTH-1:0] count;

   assign tc = inc && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= '0;
      else if (inc)
         count <= count + CWIDTH'(1);
   end

endmodule

// File: rtl/sreg_load_ctrl.sv
// Serial address-word load controller: frames MCU bits, drives the shift
// enable and latches complete words. Optional macro: SREG_AUTO_INC_EN.
module sreg_load_ctrl
   import sreg_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int CWIDTH = CWIDTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs_n,
   input  logic              bit_valid,
   input  logic              bit_in,
   input  logic              acc_strobe,
   output logic              shift_en,
   output logic              shift_data,
   output logic [DWIDTH-1:0] addr_out,
   output logic              addr_valid,
   output logic              busy,
   output logic              err_frame
);

   state_t            state, state_nx;
   logic              cs_n_q;
   logic [DWIDTH-1:0] shadow, shadow_nx;
   logic              accept, tc;
   logic              cnt_load, set_busy, clr_busy;
   logic              latch_now, enter_err, inc_addr;

   // A bit is taken only inside a frame; a bit arriving with the cs_n rise is dropped.
   assign accept    = (state == ST_SHIFT) && !cs_n && bit_valid;
   assign shadow_nx = {shadow[DWIDTH-2:0], bit_in};

`ifdef SREG_AUTO_INC_EN
   logic unused_msb;
   assign unused_msb = shadow[DWIDTH-1];
`else
   logic unused_sig;
   assign unused_sig = shadow[DWIDTH-1] ^ acc_strobe;
`endif

   sreg_bitcnt #(
      .DWIDTH (DWIDTH),
      .CWIDTH (CWIDTH)
   ) u_bitcnt (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .inc   (accept),
      .tc    (tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cnt_load  = 1'b0;
      set_busy  = 1'b0;
      clr_busy  = 1'b0;
      latch_now = 1'b0;
      enter_err = 1'b0;
      inc_addr  = 1'b0;
      case (state)
         ST_IDLE: begin
`ifdef SREG_AUTO_INC_EN
            inc_addr = acc_strobe && addr_valid;
`endif
            if (cs_n_q && !cs_n) begin
               state_nx = ST_SHIFT;
               cnt_load = 1'b1;
               set_busy = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_n) begin
               state_nx  = ST_ERROR;
               enter_err = 1'b1;
               clr_busy  = 1'b1;
            end else if (accept && tc) begin
               state_nx  = ST_LATCH;
               latch_now = 1'b1;
            end
         end
         ST_LATCH: begin
            if (cs_n) begin
               state_nx = ST_IDLE;
               clr_busy = 1'b1;
            end else if (bit_valid) begin
               state_nx  = ST_ERROR;
               enter_err = 1'b1;
            end
         end
         ST_ERROR: begin
            if (cs_n) begin
               state_nx = ST_IDLE;
               clr_busy = 1'b1;
            end
         end
      endcase
   end

   // The word is captured on the edge that enters LATCH, so addr_out never sees a partial word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_n_q     <= 1'b0;
         shadow     <= '0;
         shift_en   <= 1'b0;
         shift_data <= 1'b0;
         addr_out   <= '0;
         addr_valid <= 1'b0;
         busy       <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         cs_n_q     <= cs_n;
         shift_en   <= accept;
         shift_data <= accept & bit_in;
         if (accept)
            shadow <= shadow_nx;
         if (latch_now) begin
            addr_out   <= shadow_nx;
            addr_valid <= 1'b1;
            err_frame  <= 1'b0;
         end else if (enter_err) begin
            addr_valid <= 1'b0;
            err_frame  <= 1'b1;
         end else if (inc_addr) begin
            addr_out <= addr_out + DWIDTH'(1);
         end
         if (set_busy)
            busy <= 1'b1;
         else if (clr_busy)
            busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sreg_load_ctrl.sv
// Directed bench for sreg_load_ctrl: reset, full/short/long frames,
// coincident cs_n rise, and the acc_strobe path in either build.
module tb_sreg_load_ctrl;

   localparam int DW = 21;

   logic          clk = 1'b0;
   logic          reset;
   logic          cs_n;
   logic          bit_valid;
   logic          bit_in;
   logic          acc_strobe;
   logic          shift_en;
   logic          shift_data;
   logic [DW-1:0] addr_out;
   logic          addr_valid;
   logic          busy;
   logic          err_frame;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int base;
   logic [DW-1:0] exp_addr;

   sreg_load_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cs_n       (cs_n),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .acc_strobe (acc_strobe),
      .shift_en   (shift_en),
      .shift_data (shift_data),
      .addr_out   (addr_out),
      .addr_valid (addr_valid),
      .busy       (busy),
      .err_frame  (err_frame)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (shift_en === 1'b1) pulses++;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic exp_acc);
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = b;
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      chk("shift_en", 32'(shift_en), 32'(exp_acc));
      if (exp_acc) chk("shift_data", 32'(shift_data), 32'(b));
   endtask

   task automatic send_bits(input logic [DW-1:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[DW-1-i], 1'b1);
   endtask

   task automatic start_frame();
      @(negedge clk);
      cs_n = 1'b0;
   endtask

   task automatic end_frame();
      @(negedge clk);
      cs_n = 1'b1;
      @(negedge clk);
      chk("busy_drop", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_acc();
      @(negedge clk);
      acc_strobe = 1'b1;
      @(negedge clk);
      acc_strobe = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      cs_n       = 1'b1;
      bit_valid  = 1'b0;
      bit_in     = 1'b0;
      acc_strobe = 1'b0;
      #1;
      chk("rst_addr", 32'(addr_out), 32'd0);
      chk("rst_valid", 32'(addr_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_frame), 32'd0);
      chk("rst_shift", 32'(shift_en), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of a frame
      start_frame();
      send_bits(21'h1FFFFF, 7);
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_shift", 32'(shift_en), 32'd0);
      chk("mid_rst_data", 32'(shift_data), 32'd0);
      chk("mid_rst_addr", 32'(addr_out), 32'd0);
      cs_n = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Full frame 1ABCDE
      base = pulses;
      start_frame();
      send_bits(21'h1ABCDE, 10);
      chk("partial_addr", 32'(addr_out), 32'd0);
      chk("partial_valid", 32'(addr_valid), 32'd0);
      send_bits(21'h1ABCDE << 10, 11);
      chk("full_valid", 32'(addr_valid), 32'd1);
      chk("full_addr", 32'(addr_out), 32'h1ABCDE);
      chk("full_busy", 32'(busy), 32'd1);
      end_frame();
      chk("full_pulses", 32'(pulses - base), 32'd21);
      chk("full_err", 32'(err_frame), 32'd0);
      chk("full_valid_idle", 32'(addr_valid), 32'd1);

      // Short frame of 10 bits
      start_frame();
      send_bits(21'h0AAAAA, 10);
      end_frame();
      chk("short_err", 32'(err_frame), 32'd1);
      chk("short_valid", 32'(addr_valid), 32'd0);
      chk("short_addr", 32'(addr_out), 32'h1ABCDE);

      // Long frame of 22 bits
      start_frame();
      send_bits(21'h0F0F0F, 21);
      chk("long_latch_addr", 32'(addr_out), 32'h0F0F0F);
      chk("long_latch_err", 32'(err_frame), 32'd0);
      send_bit(1'b1, 1'b0);
      chk("long_err", 32'(err_frame), 32'd1);
      chk("long_valid", 32'(addr_valid), 32'd0);
      chk("long_busy", 32'(busy), 32'd1);
      end_frame();
      chk("long_addr", 32'(addr_out), 32'h0F0F0F);
      chk("long_err_idle", 32'(err_frame), 32'd1);

      // Good frame clears the sticky error
      start_frame();
      send_bits(21'h000100, 21);
      end_frame();
      chk("good_err", 32'(err_frame), 32'd0);
      chk("good_addr", 32'(addr_out), 32'h000100);
      chk("good_valid", 32'(addr_valid), 32'd1);

      // Final bit coincident with cs_n rise is dropped
      start_frame();
      send_bits(21'h1FFFFF, 20);
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      cs_n      = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      chk("coin_shift", 32'(shift_en), 32'd0);
      chk("coin_busy", 32'(busy), 32'd0);
      chk("coin_err", 32'(err_frame), 32'd1);
      repeat (2) @(negedge clk);
      chk("coin_valid", 32'(addr_valid), 32'd0);
      chk("coin_addr", 32'(addr_out), 32'h000100);

      // acc_strobe in IDLE and during SHIFT
      start_frame();
      send_bits(21'h1FFFFE, 21);
      end_frame();
      chk("inc_load", 32'(addr_out), 32'h1FFFFE);
`ifdef SREG_AUTO_INC_EN
      pulse_acc();
      chk("inc_1", 32'(addr_out), 32'h1FFFFF);
      pulse_acc();
      chk("inc_2", 32'(addr_out), 32'h000000);
      chk("inc_wrap_valid", 32'(addr_valid), 32'd1);
      pulse_acc();
      chk("inc_3", 32'(addr_out), 32'h000001);
      exp_addr = 21'h000001;
`else
      pulse_acc();
      chk("noinc_1", 32'(addr_out), 32'h1FFFFE);
      pulse_acc();
      chk("noinc_2", 32'(addr_out), 32'h1FFFFE);
      exp_addr = 21'h1FFFFE;
`endif
      start_frame();
      send_bits(21'h155555, 4);
      pulse_acc();
      chk("shift_acc_addr", 32'(addr_out), 32'(exp_addr));
      end_frame();
      chk("shift_acc_err", 32'(err_frame), 32'd1);
      chk("shift_acc_final", 32'(addr_out), 32'(exp_addr));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sreg_load_ctrl.md
Name: sreg_load_ctrl

Overview:
Sequences serial loading of the DWIDTH-bit address shift register in the CPLD. Framed serial bits arrive from the MCU interface; the block counts them, gates the shift enable and latches a completed word into a stable address output. It flags framing errors and, optionally, auto-increments the latched address on each memory-access strobe. Sits between the MCU serial front end and the SRAM address bus mux.

Parameters:
DWIDTH, 21, address word width in bits
CWIDTH, 5, bit-counter width; must satisfy 2**CWIDTH > DWIDTH

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
cs_n  input  1  frame select from MCU, active low; already synchronised to clk
bit_valid  input  1  one-cycle strobe: bit_in is valid this cycle
bit_in  input  1  serial data bit, MSB first
acc_strobe  input  1  one-cycle memory-access strobe (auto-increment source)
shift_en  output  1  registered shift enable to the shift register
shift_data  output  1  registered bit presented with shift_en
addr_out  output  DWIDTH  latched address
addr_valid  output  1  high once a complete word has been latched
busy  output  1  high while a frame is in progress
err_frame  output  1  sticky framing error

Behaviour:
- Reset (async): state=IDLE; bit counter=0; internal shadow shift register=0; addr_out=0; addr_valid=0; busy=0; shift_en=0; shift_data=0; err_frame=0.
- States: IDLE, SHIFT, LATCH, ERROR.
- IDLE: cs_n falling (sampled low while previously high) -> SHIFT, counter=0, busy=1. bit_valid in IDLE is ignored.
- SHIFT: each bit_valid -> shadow <= {shadow[DWIDTH-2:0], bit_in}, counter+1. shift_en/shift_data mirror the strobe one cycle later (latency 1).
  - Counter reaches DWIDTH while cs_n low -> LATCH.
  - cs_n rises with counter < DWIDTH -> ERROR (short frame).
- LATCH (1 cycle): addr_out <= shadow; addr_valid=1; busy stays 1 until cs_n high; then IDLE. A further bit_valid before cs_n rises -> ERROR (long frame); addr_out keeps the value already latched.
- ERROR: err_frame=1 (sticky); addr_valid cleared; addr_out unchanged; on cs_n high -> IDLE, busy=0. err_frame clears only at the start of the next good frame's LATCH or on reset.
- bit_valid on the same cycle as the cs_n rising edge: the bit is discarded and the edge is processed.
- addr_out changes only in LATCH (or via the auto-increment feature). It never shows a partial word.
- busy deasserts the cycle after cs_n is sampled high.

Optional Feature:
SREG_AUTO_INC_EN
- Defined: when addr_valid=1 and state=IDLE, acc_strobe increments addr_out by 1 modulo 2**DWIDTH. The all-ones value wraps to 0, and addr_valid stays 1. acc_strobe during SHIFT/LATCH/ERROR is ignored. If acc_strobe coincides with the cs_n falling edge, the increment applies first.
- Undefined: acc_strobe is ignored and addr_out changes only in LATCH.

Decomposition:
- Shared package sreg_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_LATCH=2'd2, ST_ERROR=2'd3.
  - Default DWIDTH/CWIDTH.
- One natural sub-module, sreg_bitcnt: loadable up-counter with terminal-count flag at DWIDTH.
- FSM and shadow register stay in the top module.

Test Plan:
- Reset mid-frame: assert reset after 7 bits -> all outputs 0 immediately, state IDLE. Next full frame loads correctly.
- Full frame, cs_n low, 21 bits of 21'h1ABCDE -> addr_out=21'h1ABCDE, addr_valid=1 one cycle after the 21st bit. 21 shift_en pulses, each 1 cycle after its bit_valid.
- Short frame of 10 bits, then cs_n high -> err_frame=1, addr_valid=0, addr_out keeps the previous value (21'h1ABCDE).
- Long frame of 22 bits -> err_frame=1. addr_out=value of the first 21 bits. A following good frame of 21'h000100 clears err_frame and sets addr_out=21'h000100.
- bit_valid coincident with cs_n rise on bit 21 -> treated as a short frame, err_frame=1.
- SREG_AUTO_INC_EN defined, load 21'h1FFFFE, pulse acc_strobe 3 times in IDLE -> addr_out goes 1FFFFF, 000000, 000001. acc_strobe during SHIFT leaves the value unchanged.
